// File: rtl/ldiff.sv
// ldiff: pipelined first-difference unit (inverse of the nibble-split accumulator).
// Recovers x[n] = a[n] - a[n-1] mod 2^W from a stream of running sums. The low
// half is subtracted in stage 1 with its borrow registered; the high half is
// subtracted in stage 2 using that borrow. Latency is two edges after capture.
// Optional feature macro: LDIFF_CNT_EN enables the delivered-increment counter
// on cnt; without it cnt is tied to zero.
module ldiff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         in_vld,
  input  logic [W-1:0] a,
  input  logic         clr,
  output logic         out_vld,
  output logic [W-1:0] x,
  output logic [7:0]   cnt
);

  localparam int H = W / 2;

  // Low-half subtraction; bit H of the result is the borrow out.
  function automatic logic [H:0] sub_lo(input logic [H-1:0] m, input logic [H-1:0] s);
    sub_lo = {1'b0, m} - {1'b0, s};
  endfunction

  // High-half subtraction with borrow in; the MSB borrow out is discarded.
  function automatic logic [H-1:0] sub_hi(input logic [H-1:0] m, input logic [H-1:0] s,
                                          input logic bin);
    logic [H-1:0] b_ext;
    b_ext    = {H{1'b0}};
    b_ext[0] = bin;
    sub_hi   = m - s - b_ext;
  endfunction

  // Stage 0 state
  logic [W-1:0] cur_q, cur_d, prev_q, prev_d;
  logic         v0_q, v0_d;
  // Stage 1 state
  logic [H-1:0] lo_q, lo_d, cur_hi_q, cur_hi_d, prev_hi_q, prev_hi_d;
  logic         bw_q, bw_d, v1_q, v1_d;
  // Stage 2 state
  logic [W-1:0] x_q, x_d;
  logic         out_vld_q, out_vld_d;
  logic [H:0]   lo_diff_s;

  assign lo_diff_s = sub_lo(cur_q[H-1:0], prev_q[H-1:0]);

  // Stage 0 next state: capture an accepted sample and shift the previous one.
  always_comb begin
    cur_d  = cur_q;
    prev_d = prev_q;
    v0_d   = 1'b0;
    if (clr) begin
      cur_d  = {W{1'b0}};
      prev_d = {W{1'b0}};
      v0_d   = 1'b0;
    end else if (in_vld) begin
      cur_d  = a;
      prev_d = cur_q;
      v0_d   = 1'b1;
    end else begin
      cur_d  = cur_q;
      prev_d = prev_q;
      v0_d   = 1'b0;
    end
  end

  // Stage 1 next state: low-half difference and borrow, delay the high halves.
  always_comb begin
    lo_d      = lo_q;
    bw_d      = bw_q;
    cur_hi_d  = cur_hi_q;
    prev_hi_d = prev_hi_q;
    v1_d      = 1'b0;
    if (clr) begin
      v1_d = 1'b0;
    end else if (v0_q) begin
      lo_d      = lo_diff_s[H-1:0];
      bw_d      = lo_diff_s[H];
      cur_hi_d  = cur_q[W-1:H];
      prev_hi_d = prev_q[W-1:H];
      v1_d      = 1'b1;
    end else begin
      v1_d = 1'b0;
    end
  end

  // Stage 2 next state: high-half difference; x holds when nothing valid arrives.
  always_comb begin
    x_d       = x_q;
    out_vld_d = 1'b0;
    if (clr) begin
      out_vld_d = 1'b0;
    end else if (v1_q) begin
      x_d       = {sub_hi(cur_hi_q, prev_hi_q, bw_q), lo_q};
      out_vld_d = 1'b1;
    end else begin
      out_vld_d = 1'b0;
    end
  end

  // Pipeline registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cur_q     <= {W{1'b0}};
      prev_q    <= {W{1'b0}};
      v0_q      <= 1'b0;
      lo_q      <= {H{1'b0}};
      bw_q      <= 1'b0;
      cur_hi_q  <= {H{1'b0}};
      prev_hi_q <= {H{1'b0}};
      v1_q      <= 1'b0;
      x_q       <= {W{1'b0}};
      out_vld_q <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      v0_q      <= v0_d;
      lo_q      <= lo_d;
      bw_q      <= bw_d;
      cur_hi_q  <= cur_hi_d;
      prev_hi_q <= prev_hi_d;
      v1_q      <= v1_d;
      x_q       <= x_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign x       = x_q;
  assign out_vld = out_vld_q;

`ifdef LDIFF_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter next state: one count per increment loaded into stage 2, wraps at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (v1_q) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, updates on the same edge as out_vld.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  assign cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ldiff.sv
// tb_ldiff: scoreboard bench for ldiff. The driver pushes expected increments
// (a - previous accepted a, mod 256) with their due cycle; a monitor at the
// falling edge pops and compares whenever out_vld is high.
module tb_ldiff;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       in_vld = 1'b0;
  logic [7:0] a = 8'd0;
  logic       clr = 1'b0;
  logic       out_vld;
  logic [7:0] x;
  logic [7:0] cnt;

  ldiff #(.W(8)) dut (
    .clk(clk), .rst_b(rst_b), .in_vld(in_vld), .a(a), .clr(clr),
    .out_vld(out_vld), .x(x), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] xv;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] prev_a = 8'd0;
  logic [7:0] last_x = 8'd0;
  logic [7:0] exp_cnt = 8'd0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] cnt_ref();
`ifdef LDIFF_CNT_EN
    return exp_cnt;
`else
    return 8'd0;
`endif
  endfunction

  // Apply one cycle of stimulus and update the reference model after the edge.
  task automatic step(input logic v, input logic [7:0] av, input logic c);
    in_vld = v;
    a      = av;
    clr    = c;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      prev_a  = 8'd0;
      exp_cnt = 8'd0;
    end else if (v) begin
      q.push_back('{xv: av - prev_a, due: cyc + 2});
      prev_a = av;
    end
    in_vld = 1'b0;
    clr    = 1'b0;
  endtask

  // Pulse reset between clock edges and check the immediate effect.
  task automatic pulse_reset();
    #1;
    rst_b = 1'b0;
    #1;
    chk("rst_out_vld", int'(out_vld), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_cnt", int'(cnt), 0);
    q.delete();
    prev_a  = 8'd0;
    exp_cnt = 8'd0;
    last_x  = 8'd0;
    #1;
    rst_b = 1'b1;
  endtask

  // Monitor: compare every presented output and the holding behaviour.
  always @(negedge clk) begin
    if (rst_b) begin
      if (out_vld) begin
        if (q.size() == 0) begin
          chk("spurious_out_vld", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("x", int'(x), int'(e.xv));
          chk("latency", cyc, e.due);
          last_x  = e.xv;
          exp_cnt = exp_cnt + 8'd1;
        end
      end else begin
        chk("x_hold", int'(x), int'(last_x));
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missing_out_vld", 0, 1);
          void'(q.pop_front());
        end
      end
      chk("cnt", int'(cnt), int'(cnt_ref()));
    end
  end

  initial begin
    logic [7:0] seq [5];
    seq = '{8'h01, 8'h03, 8'h06, 8'h0A, 8'h0F};
    #2;
    chk("init_out_vld", int'(out_vld), 0);
    chk("init_x", int'(x), 0);
    chk("init_cnt", int'(cnt), 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;

    // Back-to-back running sums, expected increments 1..5
    for (int i = 0; i < 5; i++) step(1'b1, seq[i], 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    chk("burst_cnt", int'(cnt), int'(cnt_ref()));

    // Cross-nibble borrow in both directions
    step(1'b1, 8'h0F, 1'b0); step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h20, 1'b0); step(1'b1, 8'h1F, 1'b0);
    // Wrap-around of the running sum
    step(1'b1, 8'hFE, 1'b0); step(1'b1, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

    // Gaps between accepted samples
    step(1'b1, 8'h10, 1'b0); step(1'b0, 8'hAA, 1'b0);
    step(1'b0, 8'h55, 1'b0); step(1'b1, 8'h15, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

    // Clear with two samples in flight; the clr-edge sample is discarded
    step(1'b1, 8'h40, 1'b0); step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h33, 1'b1);
    chk("clr_cnt", int'(cnt), 0);
    step(1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

    // Asynchronous reset mid-stream
    step(1'b1, 8'h21, 1'b0); step(1'b1, 8'h22, 1'b0);
    pulse_reset();
    step(1'b1, 8'h09, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        step(1'b1, 8'($urandom), 1'b0);
        pulse_reset();
      end else if (r < 4) begin
        step(1'($urandom), 8'($urandom), 1'b1);
      end else begin
        step(($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
      end
    end

    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
